// File: rtl/ps2_decoder.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 bus, deframes
// 11-bit frames and folds E0/F0 prefixes into a single key event.
module ps2_decoder #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_in,
  output logic       ext,
  output logic       key_released,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic               dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic               filt_q, filt_d;
  logic [FILT_W-1:0]  filt_cnt_q, filt_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_ok_q, par_ok_d;
  logic               ext_pend_q, ext_pend_d;
  logic               rel_pend_q, rel_pend_d;
  logic [7:0]         key_q, key_d;
  logic               ext_q, ext_d;
  logic               rel_q, rel_d;
  logic               key_valid_q, key_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               fall_c;

  // Next-state logic for synchronizers, glitch filter, frame FSM and key tracking
  always_comb begin
    state_d     = state_q;
    clk_s1_d    = ps2_clk;
    clk_s2_d    = clk_s1_q;
    dat_s1_d    = ps2_data;
    dat_s2_d    = dat_s1_q;
    filt_d      = filt_q;
    filt_cnt_d  = filt_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    ext_pend_d  = ext_pend_q;
    rel_pend_d  = rel_pend_q;
    key_d       = key_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    fall_c      = 1'b0;

    // Filtered level flips only after FILTER_LEN consecutive differing samples
    if (clk_s2_q == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
      filt_d     = clk_s2_q;
      filt_cnt_d = '0;
      fall_c     = filt_q;
    end else begin
      filt_cnt_d = filt_cnt_q + FILT_W'(1);
    end

    if (state_q == S_IDLE || fall_c) tmo_cnt_d = '0;
    else                             tmo_cnt_d = tmo_cnt_q + TMO_W'(1);

    case (state_q)
      S_IDLE: begin
        if (fall_c) begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            rel_pend_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (fall_c) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall_c) begin
          par_ok_d = ^{dat_s2_q, shift_q};
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (fall_c) begin
          state_d = S_IDLE;
          if (dat_s2_q && par_ok_q) begin
            if (shift_q == 8'hE0) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              rel_pend_d = 1'b1;
            end else begin
              key_d       = shift_q;
              ext_d       = ext_pend_q;
              rel_d       = rel_pend_q;
              key_valid_d = 1'b1;
              ext_pend_d  = 1'b0;
              rel_pend_d  = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            rel_pend_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stalled mid-frame bus: abandon the frame (never coincides with a falling edge)
    if (state_q != S_IDLE && !fall_c && tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      rel_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_ok_q    <= 1'b0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      key_q       <= 8'h00;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      ext_pend_q  <= ext_pend_d;
      rel_pend_q  <= rel_pend_d;
      key_q       <= key_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign key_in       = key_q;
  assign ext          = ext_q;
  assign key_released = rel_q;
  assign key_valid    = key_valid_q;
  assign frame_err    = frame_err_q;

endmodule

// File: doc/ps2_decoder.md
PS2_DECODER -- requirements
Module: ps2_decoder

Interface
REQ-001 FILTER_LEN, 8, consecutive identical synchronized ps2_clk samples required before the filtered clock changes level.
REQ-002 TIMEOUT_CYC, 50000, clk cycles without a filtered falling edge mid-frame before the frame is aborted.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 key_in  output  8  last completed non-prefix scan code; held until the next one completes.
REQ-008 ext  output  1  E0 prefix preceded key_in; held with key_in.
REQ-009 key_released  output  1  F0 prefix preceded key_in (break code); held with key_in.
REQ-010 key_valid  output  1  one-cycle strobe; key_in/ext/key_released updated this cycle.
REQ-011 frame_err  output  1  one-cycle strobe on a discarded frame.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 Filtered clock SHALL take the synchronized ps2_clk level only after FILTER_LEN consecutive equal samples; shorter glitches SHALL be ignored.
REQ-014 Bit sampling SHALL occur only on the clk cycle a filtered 1->0 transition is detected, sampling synchronized ps2_data.
REQ-015 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP; a 3-bit counter SHALL index DATA bits 0..7, LSB first.
REQ-016 IDLE: falling edge with data=0 -> DATA; falling edge with data=1 -> stay IDLE, pulse frame_err.
REQ-017 DATA: shift a bit per falling edge; after bit 7 -> PARITY.
REQ-018 PARITY: sampled bit SHALL make the 9-bit {parity,data} odd; record the result; -> STOP.
REQ-019 STOP: on a falling edge -> IDLE; frame good only if stop=1 and parity odd, else pulse frame_err and discard.
REQ-020 Good byte E0 SHALL set ext_pend; good byte F0 SHALL set rel_pend; in either order, repeats harmless; no key_valid.
REQ-021 Any other good byte SHALL load key_in=byte, ext=ext_pend, key_released=rel_pend, pulse key_valid, and clear both pending flags, all on the same clk edge.
REQ-022 Any frame_err (start, parity, stop, timeout) SHALL clear ext_pend and rel_pend and leave key_in/ext/key_released unchanged.
REQ-023 Timeout counter SHALL reset on every filtered falling edge and in IDLE; reaching TIMEOUT_CYC in DATA/PARITY/STOP -> IDLE and pulse frame_err.
REQ-024 key_valid SHALL rise no more than FILTER_LEN+4 clk cycles after the raw stop-bit falling edge.
REQ-025 key_valid and frame_err SHALL never assert in the same cycle; each SHALL be exactly one cycle wide.

Reset
REQ-026 reset low SHALL immediately clear key_in=8'h00, ext=0, key_released=0, key_valid=0, frame_err=0, FSM=IDLE, counters, pending flags; synchronizers and filter SHALL reset to 1 (idle bus).
REQ-027 reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL decode normally.

Verification
REQ-028 Frame 0x5A, parity 1 -> one key_valid, key_in=8'h5A, ext=0, key_released=0.
REQ-029 Frames E0, F0, 75 -> single key_valid after third frame, key_in=8'h75, ext=1, key_released=1; no strobe after E0 or F0.
REQ-030 Frame 0x6B with parity 1 (even) -> frame_err one cycle, no key_valid, outputs hold previous values; next frame E0 6B -> ext=1, key_released=0 (no stale flags).
REQ-031 ps2_clk glitch low for FILTER_LEN-1 cycles in IDLE -> no state change, no strobe.
REQ-032 Start bit and 4 data bits, then bus idle for TIMEOUT_CYC cycles -> frame_err, FSM IDLE; next full frame 0x72 decodes to key_in=8'h72.
REQ-033 reset pulsed low after F0 and half of a following frame -> all outputs 0; subsequent frame 0x74 -> key_released=0, ext=0, key_in=8'h74.
